// File: rtl/register_pair_sequencer_pkg.sv
// Shared CPU definitions for register-pair sequencing: op encodings, pair
// indices, the pair-to-register mapping and the sequencer FSM states.
// Optional build macro: REG_PAIR_SEQ_VERIFY_EN adds the readback-verify states.
package register_pair_sequencer_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned WORD_W    = 16;
  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned PAIR_W    = 2;
  localparam int unsigned OP_W      = 2;
  localparam int unsigned CNT_W     = 2;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD16 = 2'd0,
    OP_INC16  = 2'd1,
    OP_DEC16  = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  localparam logic [PAIR_W-1:0] PAIR_0 = 2'd0;
  localparam logic [PAIR_W-1:0] PAIR_1 = 2'd1;
  localparam logic [PAIR_W-1:0] PAIR_2 = 2'd2;
  localparam logic [PAIR_W-1:0] PAIR_3 = 2'd3;

`ifdef REG_PAIR_SEQ_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_CALC, S_WRITE_HI, S_WRITE_LO,
    S_VERIFY_WAIT, S_VERIFY, S_DONE
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_CALC, S_WRITE_HI, S_WRITE_LO, S_DONE
  } state_e;
`endif

  // Command captured when start is accepted
  typedef struct packed {
    op_e               op;
    logic [PAIR_W-1:0] pair;
  } cmd_t;

  // High byte of pair p lives in register 2p, low byte in 2p+1
  function automatic logic [REG_IDX_W-1:0] hi_reg(input logic [PAIR_W-1:0] p);
    return {p, 1'b0};
  endfunction

  function automatic logic [REG_IDX_W-1:0] lo_reg(input logic [PAIR_W-1:0] p);
    return {p, 1'b1};
  endfunction

endpackage

// File: rtl/reg_pair_incdec.sv
// Combinational 16-bit +/-1 unit (wraps modulo 2^16).
// Ports: i_value - operand; i_dec - 1 selects decrement;
//        o_value_c - i_value +/- 1 (combinational).
module reg_pair_incdec
  import register_pair_sequencer_pkg::*;
(
  input  logic [WORD_W-1:0] i_value,
  input  logic              i_dec,
  output logic [WORD_W-1:0] o_value_c
);

  assign o_value_c = i_dec ? (i_value - WORD_W'(1)) : (i_value + WORD_W'(1));

endmodule

// File: rtl/register_pair_sequencer.sv
// Sequences 16-bit register-pair operations (LD rr,nn / INC rr / DEC rr) as
// two 8-bit RegisterBank writes, high byte first, with a start/busy/done
// handshake toward the control unit.
// Ports: clk, reset (async active-low); start/op/pairSel/loadValue command
//        inputs; bankDataOut16 bank readback; bankRegNum/bankDataIn/
//        bankWriteEnable bank controls; busy, done, result, verifyError status.
// Parameter: READ_LATENCY (1..3) cycles from regNum change to valid dataOut16.
// Optional build macro: REG_PAIR_SEQ_VERIFY_EN enables post-write readback
// verification and the sticky verifyError flag.
module register_pair_sequencer
  import register_pair_sequencer_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [OP_W-1:0]      op,
  input  logic [PAIR_W-1:0]    pairSel,
  input  logic [WORD_W-1:0]    loadValue,
  input  logic [WORD_W-1:0]    bankDataOut16,
  output logic [REG_IDX_W-1:0] bankRegNum,
  output logic [DATA_W-1:0]    bankDataIn,
  output logic                 bankWriteEnable,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_W-1:0]    result,
  output logic                 verifyError
);

  state_e               r_state,    w_state_next;
  cmd_t                 r_cmd,      w_cmd_next;
  logic [WORD_W-1:0]    r_result,   w_result_next;
  logic [CNT_W-1:0]     r_wait_cnt, w_wait_cnt_next;
  logic [REG_IDX_W-1:0] r_reg_num,  w_reg_num_next;
  logic [DATA_W-1:0]    r_data_in,  w_data_in_next;
  logic                 r_we,       w_we_next;
  logic                 r_done,     w_done_next;
  logic                 r_busy,     w_busy_next;
  logic [WORD_W-1:0]    w_incdec;
  logic                 w_dec;

  assign w_dec = (r_cmd.op == OP_DEC16);

  reg_pair_incdec u_incdec (
    .i_value   (bankDataOut16),
    .i_dec     (w_dec),
    .o_value_c (w_incdec)
  );

`ifdef REG_PAIR_SEQ_VERIFY_EN
  logic r_verify_err, w_verify_err_next;
`endif

  // Next-state and next-output decode; bank controls lag the state by one
  // cycle so each write lands on the edge after its WRITE_* state.
  always_comb begin
    w_state_next    = r_state;
    w_cmd_next      = r_cmd;
    w_result_next   = r_result;
    w_wait_cnt_next = r_wait_cnt;
    w_reg_num_next  = r_reg_num;
    w_data_in_next  = r_data_in;
    w_we_next       = 1'b0;
    w_done_next     = 1'b0;
`ifdef REG_PAIR_SEQ_VERIFY_EN
    w_verify_err_next = r_verify_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cmd_next.op   = op_e'(op);
          w_cmd_next.pair = pairSel;
          case (op_e'(op))
            OP_LOAD16: begin
              w_result_next = loadValue;
              w_state_next  = S_WRITE_HI;
            end
            OP_INC16, OP_DEC16: begin
              w_reg_num_next  = hi_reg(pairSel);
              w_wait_cnt_next = CNT_W'(READ_LATENCY);
              w_state_next    = S_WAIT;
            end
            default: w_state_next = S_DONE;
          endcase
        end
      end
      S_WAIT: begin
        w_wait_cnt_next = r_wait_cnt - CNT_W'(1);
        if (r_wait_cnt == CNT_W'(1)) w_state_next = S_CALC;
      end
      S_CALC: begin
        w_result_next = w_incdec;
        w_state_next  = S_WRITE_HI;
      end
      S_WRITE_HI: begin
        w_reg_num_next = hi_reg(r_cmd.pair);
        w_data_in_next = r_result[WORD_W-1:DATA_W];
        w_we_next      = 1'b1;
        w_state_next   = S_WRITE_LO;
      end
      S_WRITE_LO: begin
        w_reg_num_next = lo_reg(r_cmd.pair);
        w_data_in_next = r_result[DATA_W-1:0];
        w_we_next      = 1'b1;
`ifdef REG_PAIR_SEQ_VERIFY_EN
        w_wait_cnt_next = CNT_W'(READ_LATENCY);
        w_state_next    = S_VERIFY_WAIT;
`else
        w_state_next    = S_DONE;
`endif
      end
`ifdef REG_PAIR_SEQ_VERIFY_EN
      S_VERIFY_WAIT: begin
        w_reg_num_next  = hi_reg(r_cmd.pair);
        w_wait_cnt_next = r_wait_cnt - CNT_W'(1);
        if (r_wait_cnt == CNT_W'(1)) w_state_next = S_VERIFY;
      end
      S_VERIFY: begin
        if (bankDataOut16 != r_result) w_verify_err_next = 1'b1;
        w_state_next = S_DONE;
      end
`endif
      S_DONE: begin
        w_done_next  = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    w_busy_next = (w_state_next != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cmd      <= '0;
      r_result   <= '0;
      r_wait_cnt <= '0;
      r_reg_num  <= '0;
      r_data_in  <= '0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cmd      <= w_cmd_next;
      r_result   <= w_result_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_reg_num  <= w_reg_num_next;
      r_data_in  <= w_data_in_next;
      r_we       <= w_we_next;
      r_done     <= w_done_next;
      r_busy     <= w_busy_next;
    end
  end

`ifdef REG_PAIR_SEQ_VERIFY_EN
  // Sticky readback-mismatch flag, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_verify_err <= 1'b0;
    else        r_verify_err <= w_verify_err_next;
  end
  assign verifyError = r_verify_err;
`else
  assign verifyError = 1'b0;
`endif

  assign bankRegNum      = r_reg_num;
  assign bankDataIn      = r_data_in;
  assign bankWriteEnable = r_we;
  assign busy            = r_busy;
  assign done            = r_done;
  assign result          = r_result;

endmodule

// File: doc/register_pair_sequencer.md
Name: register_pair_sequencer

Overview:
- Sits directly upstream of RegisterBank and drives its regNum, dataIn and writeEnable inputs. It also consumes the bank's dataOut16.
- Executes 16-bit register-pair operations (LD rr,nn / INC rr / DEC rr) as two 8-bit bank writes: high byte first, then low byte.
- Provides a start/busy/done handshake to the CPU control unit.

Parameters:
- READ_LATENCY, 1, cycles from a regNum change until the bank's dataOut16 is valid; legal range 1..3.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  command request; sampled only in IDLE.
- op  input  2  command: 0=LOAD16, 1=INC16, 2=DEC16, 3=reserved (treated as NOP: done pulse, no writes).
- pairSel  input  2  pair index p; the pair is registers 2p (high byte) and 2p+1 (low byte).
- loadValue  input  16  LOAD16 value; captured when start is accepted.
- bankDataOut16  input  16  from RegisterBank dataOut16, {reg[2p], reg[2p+1]}.
- bankRegNum  output  3  to RegisterBank regNum.
- bankDataIn  output  8  to RegisterBank dataIn.
- bankWriteEnable  output  1  to RegisterBank writeEnable.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when a command completes.
- result  output  16  value written by the last command; holds until the next command.
- verifyError  output  1  readback mismatch; see Optional Feature.

Behaviour:
- Reset (async, reset=0):
  - State goes to IDLE.
  - bankRegNum=0, bankDataIn=0, bankWriteEnable=0, busy=0, done=0, result=0, verifyError=0.
  - bankWriteEnable drops immediately on reset assertion, without waiting for a clock edge.
- Outputs are registered, or decoded from the state register only (Moore); there are no combinational paths from inputs to outputs.
- States: IDLE, WAIT, CALC, WRITE_HI, WRITE_LO, [VERIFY_WAIT, VERIFY], DONE.
- IDLE, start=1 at edge N:
  - Latch op, pairSel and loadValue.
  - LOAD16 -> WRITE_HI, with result=loadValue.
  - INC16/DEC16 -> WAIT, with bankRegNum=2p and a wait counter loaded with READ_LATENCY.
  - Reserved op -> DONE.
- WAIT: decrement the counter; when it reaches 0 -> CALC. Exactly READ_LATENCY cycles are spent in WAIT.
- CALC:
  - result = bankDataOut16 +1 (INC16) or -1 (DEC16), modulo 2^16: 0xFFFF+1=0x0000 and 0x0000-1=0xFFFF.
  - Next state is WRITE_HI.
- WRITE_HI: bankRegNum=2p, bankDataIn=result[15:8], bankWriteEnable=1 for exactly one cycle.
- WRITE_LO: bankRegNum=2p+1, bankDataIn=result[7:0], bankWriteEnable=1 for exactly one cycle.
- DONE: done=1 for one cycle, then -> IDLE.
- bankWriteEnable is 0 in every state except WRITE_HI and WRITE_LO.
- Latency:
  - LOAD16: start edge N; high byte written at edge N+2, low byte at edge N+3; done high during cycle N+3..N+4.
  - INC16/DEC16: add READ_LATENCY+1 cycles to the LOAD16 figures.
- Back-to-back commands:
  - start while busy=1 is ignored and not queued.
  - A start held high through DONE is accepted on the first IDLE cycle; minimum issue interval is 4 cycles for LOAD16.
- Reset mid-operation aborts the command.
  - If only WRITE_HI has completed, the pair is left half-written; this is accepted behaviour.
  - No done pulse is issued for the aborted command.
- pairSel and op changes while busy have no effect.

Optional Feature:
- Macro: REG_PAIR_SEQ_VERIFY_EN.
- Defined:
  - After WRITE_LO, enter VERIFY_WAIT with bankRegNum=2p for READ_LATENCY cycles, then VERIFY.
  - VERIFY compares bankDataOut16 to result.
  - On mismatch, verifyError is set sticky and cleared only by reset.
  - Then -> DONE. Adds READ_LATENCY+1 cycles to every write command.
- Not defined: the VERIFY states are absent and verifyError is tied to 0.

Decomposition:
- Shared CPU package/header: op encodings (OP_LOAD16, OP_INC16, OP_DEC16), pair indices (PAIR_0..PAIR_3), and the register-index mapping (high = 2p, low = 2p+1).
- One natural sub-module: reg_pair_incdec, a combinational 16-bit ±1 unit (inputs value and dec; output value±1 mod 2^16). It is shared later with the SP/PC incrementer.
- FSM and handshake stay in the top module.

Test Plan:
- LOAD16: p=1, loadValue=0xBEEF, start one cycle -> writes reg2=0xBE then reg3=0xEF on consecutive cycles; done single pulse; result=0xBEEF; bank reads 0xBEEF for regNum 2 and 3.
- INC16 wrap: reg0/reg1 preloaded 0xFF/0xFF, p=0 -> result=0x0000; reg0=0x00, reg1=0x00; done at start+READ_LATENCY+4 edges.
- DEC16 wrap: reg6/reg7 = 0x00/0x00, p=3 -> 0xFFFF. Also DEC16 on 0xDEAD -> 0xDEAC, with only reg7 changing value.
- Busy rejection: LOAD16 0x1234 to p=2, then start with p=0 one cycle later -> second start ignored; reg0/reg1 unchanged; exactly one done pulse.
- Reset mid-op: assert reset during WRITE_LO -> bankWriteEnable low immediately; busy=0; no done pulse; next LOAD16 after release completes normally.
- With REG_PAIR_SEQ_VERIFY_EN: bench forces reg3 to 0x00 between WRITE_LO and VERIFY -> verifyError=1 and stays 1 until reset. A clean run leaves verifyError=0.
